// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtract controller.
package serial_sub_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_bit_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module fs_bit_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   // Difference and borrow from the three inputs, bi included in both terms.
   always_comb begin
      d  = x ^ y ^ bi;
      bo = (~x & y) | (~x & bi) | (y & bi);
   end

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial W-bit subtractor: diff = a - b - bin, one bit per cycle LSB-first
// through a single shared full-subtractor cell.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | ready for a request; start loads operands
//   ST_RUN  | one bit per cycle through the cell; leaves after bit W-1
//   ST_DONE | result presented with out_valid; waits for out_ready
module serial_sub_ctrl
   import serial_sub_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         ready,
   output logic         busy,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] diff,
   output logic         bout,
   output logic         ovf
);

   localparam int               CNT_W    = $clog2(W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

   state_t             state_q, state_d;
   logic [W-1:0]       sa_q, sa_d;
   logic [W-1:0]       sb_q, sb_d;
   // Holds the W-1 low result bits; the final bit joins them straight from the cell.
   logic [W-2:0]       dreg_q, dreg_d;
   logic               brw_q, brw_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               amsb_q, amsb_d;
   logic               bmsb_q, bmsb_d;
   logic [W-1:0]       diff_q, diff_d;
   logic               bout_q, bout_d;
   logic               ovf_q, ovf_d;

   logic               cell_d, cell_bo;
   logic [W-1:0]       shift_in;

   fs_bit_cell u_cell (
      .x  (sa_q[0]),
      .y  (sb_q[0]),
      .bi (brw_q),
      .d  (cell_d),
      .bo (cell_bo)
   );

   assign shift_in = {cell_d, dreg_q};

   // Next-state, datapath updates and status outputs.
   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      dreg_d    = dreg_q;
      brw_d     = brw_q;
      cnt_d     = cnt_q;
      amsb_d    = amsb_q;
      bmsb_d    = bmsb_q;
      diff_d    = diff_q;
      bout_d    = bout_q;
      ovf_d     = ovf_q;
      ready     = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) begin
               sa_d    = a;
               sb_d    = b;
               brw_d   = bin;
               cnt_d   = '0;
               amsb_d  = a[W-1];
               bmsb_d  = b[W-1];
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            busy   = 1'b1;
            sa_d   = sa_q >> 1;
            sb_d   = sb_q >> 1;
            brw_d  = cell_bo;
            dreg_d = shift_in[W-1:1];
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               diff_d  = shift_in;
               bout_d  = cell_bo;
               ovf_d   = (amsb_q != bmsb_q) && (cell_d != amsb_q);
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, shift registers, counter and registered result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         dreg_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         dreg_q  <= dreg_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl (W=8): directed vectors, output hold, async abort,
// and randomized back-to-back jobs against an arithmetic reference.
module tb_serial_sub_ctrl;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       bin;
   logic       ready;
   logic       busy;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] diff;
   logic       bout;
   logic       ovf;

   int checks = 0;
   int errors = 0;

   serial_sub_ctrl #(.W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .ready     (ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   // One job: reference computed from plain arithmetic, then latency, result,
   // hold-while-stalled and release are checked.
   task automatic do_job(input logic [7:0] ai, input logic [7:0] bi, input logic bini,
                         input int hold, input bit wiggle);
      logic [8:0] full;
      int         sd;
      logic       exp_ovf;
      int         n;
      full    = {1'b0, ai} - {1'b0, bi} - {8'd0, bini};
      sd      = int'($signed(ai)) - int'($signed(bi)) - int'(bini);
      exp_ovf = (sd < -128) || (sd > 127);

      @(negedge clk);
      a = ai; b = bi; bin = bini; start = 1'b1; out_ready = 1'b0;
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_wait: ready=%b required 1", ready);
         return;
      end

      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            checks++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
               errors++;
               $display("FAIL run_flags: busy=%b ready=%b required busy=1 ready=0", busy, ready);
            end
         end
         if (wiggle) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            start = 1'($urandom); out_ready = 1'($urandom);
         end
      end while (out_valid !== 1'b1 && n < 40);
      out_ready = (hold == 0);

      checks++;
      if (n != 9) begin
         errors++;
         $display("FAIL latency: out_valid after %0d edges required 9", n);
      end
      checks++;
      if (diff !== full[7:0] || bout !== full[8] || ovf !== exp_ovf) begin
         errors++;
         $display("FAIL result a=%h b=%h bin=%b: got diff=%h bout=%b ovf=%b required diff=%h bout=%b ovf=%b",
                  ai, bi, bini, diff, bout, ovf, full[7:0], full[8], exp_ovf);
      end

      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (wiggle) start = 1'($urandom);
         checks++;
         if (out_valid !== 1'b1 || diff !== full[7:0] || bout !== full[8] || ovf !== exp_ovf) begin
            errors++;
            $display("FAIL hold cycle %0d: out_valid=%b diff=%h required out_valid=1 diff=%h",
                     h, out_valid, diff, full[7:0]);
         end
      end
      out_ready = 1'b1;

      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || ready !== 1'b1 || diff !== full[7:0] || bout !== full[8]) begin
         errors++;
         $display("FAIL release: out_valid=%b ready=%b diff=%h required 0/1/%h",
                  out_valid, ready, diff, full[7:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
      #12;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
          diff !== 8'h00 || bout !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: ready=%b busy=%b out_valid=%b diff=%h bout=%b ovf=%b required 1 0 0 00 0 0",
                  ready, busy, out_valid, diff, bout, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: ready=%b out_valid=%b required 1 0", ready, out_valid);
      end
   endtask

   task automatic test_directed();
      do_job(8'h05, 8'h03, 1'b0, 0, 1'b0);
      do_job(8'h03, 8'h05, 1'b0, 0, 1'b0);
      do_job(8'h00, 8'h00, 1'b1, 0, 1'b0);
      do_job(8'h80, 8'h01, 1'b0, 0, 1'b0);
      do_job(8'h7F, 8'hFF, 1'b0, 1, 1'b0);
      do_job(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
   endtask

   task automatic test_hold();
      do_job(8'h5A, 8'h3C, 1'b1, 5, 1'b1);
   endtask

   task automatic test_abort();
      @(negedge clk);
      a = 8'hC3; b = 8'h11; bin = 1'b0; start = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
         errors++;
         $display("FAIL abort: ready=%b busy=%b out_valid=%b diff=%h bout=%b required 1 0 0 00 0",
                  ready, busy, out_valid, diff, bout);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_job(8'h10, 8'h20, 1'b1, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int j = 0; j < 3000; j++) begin
         do_job(8'($urandom), 8'($urandom), 1'($urandom),
                int'($urandom_range(0, 2)), bit'(j % 4 == 3));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
